// File: rtl/fish_spawn_scheduler.sv
// Fish scheduler: arming delay, spawn, horizontal sweep with wrap, hold while hooked; all outputs registered, one clk after a tick.
// No backpressure: state only moves on tick, the LFSR and spawn_pulse clear run every clk.
module fish_spawn_scheduler #(
   parameter int unsigned X_START     = 798,
   parameter int unsigned X_END       = 144,
   parameter int unsigned SPEED       = 2,
   parameter int unsigned ARM_TICKS   = 400,
   parameter int unsigned JITTER_BITS = 6,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic [1:0] level,
   input  logic       activity,
   input  logic       hooked,
   input  logic       caught_done,
   output logic [9:0] fish_x,
   output logic [9:0] fish_y,
   output logic       fish_visible,
   output logic       spawn_pulse,
   output logic [1:0] sched_state,
   output logic [7:0] sweep_count
);

   localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
   localparam int unsigned JIT_MAX  = (1 << JITTER_BITS) - 1;
   localparam logic [9:0]  JIT_MASK = 10'(JIT_MAX);

   generate
      if (JITTER_BITS > 8 || ARM_TICKS + JIT_MAX > 1023) begin : g_bad_params
         $error("fish_spawn_scheduler: arming target does not fit in 10 bits");
      end
   endgenerate

   typedef enum logic [1:0] {
      ARMING = 2'd0,
      SWEEP  = 2'd1,
      HOOKED = 2'd2
   } state_t;

   state_t      state_q;
   logic [9:0]  x_q;
   logic [9:0]  y_q;
   logic [9:0]  cnt_q;
   logic [9:0]  tgt_q;
   logic [7:0]  sweep_q;
   logic        spawn_q;
   logic        vis_q;
   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   logic [10:0] step_w;
   logic        wrap_w;
   logic [9:0]  drawn_tgt;

   function automatic logic [9:0] lane_y(input logic [1:0] lvl);
      case (lvl)
         2'd0:    lane_y = 10'd470;
         2'd1:    lane_y = 10'd380;
         2'd2:    lane_y = 10'd290;
         default: lane_y = 10'd200;
      endcase
   endfunction

   // Fibonacci taps 16,14,13,11; free-running so jitter depends on clk-level timing of the wrap.
   assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign step_w    = 11'(SPEED) + {9'd0, level};
   assign wrap_w    = ({1'b0, x_q} < (11'(X_END) + step_w));
   assign drawn_tgt = 10'(ARM_TICKS) + (lfsr_q[9:0] & JIT_MASK);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ARMING;
         x_q     <= 10'(X_START);
         y_q     <= 10'd470;
         cnt_q   <= 10'd0;
         tgt_q   <= 10'(ARM_TICKS);
         sweep_q <= 8'd0;
         spawn_q <= 1'b0;
         vis_q   <= 1'b0;
         lfsr_q  <= SEED_EFF;
      end else begin
         lfsr_q  <= lfsr_d;
         spawn_q <= 1'b0;
         if (tick) begin
            case (state_q)
               ARMING: begin
                  y_q   <= lane_y(level);
                  vis_q <= 1'b0;
                  if (activity) begin
                     if (cnt_q == tgt_q - 10'd1) begin
                        state_q <= SWEEP;
                        vis_q   <= 1'b1;
                        x_q     <= 10'(X_START);
                        spawn_q <= 1'b1;
                     end else begin
                        cnt_q <= cnt_q + 10'd1;
                     end
                  end
               end
               SWEEP: begin
                  // A catch on the wrap tick wins: the fish stays where it was hooked.
                  if (hooked) begin
                     state_q <= HOOKED;
                  end else if (wrap_w) begin
                     state_q <= ARMING;
                     vis_q   <= 1'b0;
                     x_q     <= 10'(X_START);
                     cnt_q   <= 10'd0;
                     tgt_q   <= drawn_tgt;
                     if (sweep_q != 8'hFF) sweep_q <= sweep_q + 8'd1;
                  end else begin
                     x_q <= x_q - step_w[9:0];
                  end
               end
               HOOKED: begin
                  if (caught_done) begin
                     state_q <= ARMING;
                     vis_q   <= 1'b0;
                     x_q     <= 10'(X_START);
                     y_q     <= lane_y(level);
                     cnt_q   <= 10'd0;
                     tgt_q   <= drawn_tgt;
                  end
               end
               default: begin
                  state_q <= ARMING;
                  vis_q   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign fish_x       = x_q;
   assign fish_y       = y_q;
   assign fish_visible = vis_q;
   assign spawn_pulse  = spawn_q;
   assign sched_state  = state_q;
   assign sweep_count  = sweep_q;

endmodule

// File: tb/tb_fish_spawn_scheduler.sv
// Bench for fish_spawn_scheduler: two instances (long jittered arming, short fixed arming) share stimulus;
// a per-instance reference model feeds a scoreboard queue drained on the falling edge.
module tb_fish_spawn_scheduler;

   localparam int A_ARM = 400;
   localparam int A_JB  = 6;
   localparam int B_ARM = 4;
   localparam int B_JB  = 0;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic [1:0] level = 2'd0;
   logic       activity = 1'b0;
   logic       hooked = 1'b0;
   logic       caught_done = 1'b0;

   logic [9:0] a_x, a_y, b_x, b_y;
   logic       a_vis, a_sp, b_vis, b_sp;
   logic [1:0] a_st, b_st;
   logic [7:0] a_sw, b_sw;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   fish_spawn_scheduler #(.ARM_TICKS(A_ARM), .JITTER_BITS(A_JB)) dut_a (
      .clk(clk), .rst(rst), .tick(tick), .level(level), .activity(activity),
      .hooked(hooked), .caught_done(caught_done), .fish_x(a_x), .fish_y(a_y),
      .fish_visible(a_vis), .spawn_pulse(a_sp), .sched_state(a_st), .sweep_count(a_sw));

   fish_spawn_scheduler #(.ARM_TICKS(B_ARM), .JITTER_BITS(B_JB)) dut_b (
      .clk(clk), .rst(rst), .tick(tick), .level(level), .activity(activity),
      .hooked(hooked), .caught_done(caught_done), .fish_x(b_x), .fish_y(b_y),
      .fish_visible(b_vis), .spawn_pulse(b_sp), .sched_state(b_st), .sweep_count(b_sw));

   // ---------------- reference model ----------------
   typedef struct {
      int st;
      int x;
      int y;
      int cnt;
      int tgt;
      int sw;
      bit sp;
      int lfsr;
   } mdl_t;

   function automatic int lane(int l);
      return 470 - 90 * l;
   endfunction

   function automatic int lfsr_next(int v);
      int fb;
      fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
      return ((v << 1) | fb) & 16'hFFFF;
   endfunction

   function automatic mdl_t mreset(int arm);
      mdl_t r;
      r.st = 0; r.x = 798; r.y = 470; r.cnt = 0; r.tgt = arm;
      r.sw = 0; r.sp = 1'b0; r.lfsr = 16'hACE1;
      return r;
   endfunction

   function automatic mdl_t mstep(mdl_t s, int arm, int jb, bit tk, int lvl, bit act, bit hk, bit cd);
      mdl_t n;
      int   stp;
      int   drawn;
      n     = s;
      drawn = arm + (s.lfsr % (1 << jb));
      n.lfsr = lfsr_next(s.lfsr);
      n.sp   = 1'b0;
      if (tk) begin
         if (s.st == 0) begin
            n.y = lane(lvl);
            if (act) begin
               if (s.cnt == s.tgt - 1) begin
                  n.st = 1; n.x = 798; n.sp = 1'b1;
               end else begin
                  n.cnt = s.cnt + 1;
               end
            end
         end else if (s.st == 1) begin
            stp = 2 + lvl;
            if (hk) begin
               n.st = 2;
            end else if (s.x < 144 + stp) begin
               n.st = 0; n.x = 798; n.cnt = 0; n.tgt = drawn;
               n.sw = (s.sw < 255) ? s.sw + 1 : 255;
            end else begin
               n.x = s.x - stp;
            end
         end else if (s.st == 2) begin
            if (cd) begin
               n.st = 0; n.x = 798; n.y = lane(lvl); n.cnt = 0; n.tgt = drawn;
            end
         end
      end
      return n;
   endfunction

   mdl_t ma, mb;
   mdl_t qa[$];
   mdl_t qb[$];

   initial begin
      ma = mreset(A_ARM);
      mb = mreset(B_ARM);
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            ma = mreset(A_ARM);
            mb = mreset(B_ARM);
            qa.delete();
            qb.delete();
         end else begin
            ma = mstep(ma, A_ARM, A_JB, tick, int'(level), activity, hooked, caught_done);
            mb = mstep(mb, B_ARM, B_JB, tick, int'(level), activity, hooked, caught_done);
            qa.push_back(ma);
            qb.push_back(mb);
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   task automatic sb_cmp(string who, mdl_t e, logic [9:0] x, logic [9:0] y, logic vis,
                         logic sp, logic [1:0] st, logic [7:0] sw);
      bit ok;
      ok = (int'(x) == e.x) && (int'(y) == e.y) && (vis === (e.st != 0)) &&
           (sp === e.sp) && (int'(st) == e.st) && (int'(sw) == e.sw);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL sb_%s t=%0t: got x=%0d y=%0d vis=%0d sp=%0d st=%0d sw=%0d, expected x=%0d y=%0d vis=%0d sp=%0d st=%0d sw=%0d",
                  who, $time, x, y, vis, sp, st, sw, e.x, e.y, (e.st != 0), e.sp, e.st, e.sw);
      end
   endtask

   initial begin
      mdl_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (qa.size() > 0) begin
               e = qa.pop_front();
               sb_cmp("a", e, a_x, a_y, a_vis, a_sp, a_st, a_sw);
            end
            if (qb.size() > 0) begin
               e = qb.pop_front();
               sb_cmp("b", e, b_x, b_y, b_vis, b_sp, b_st, b_sw);
            end
         end
      end
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not finish, got t=%0t required completion", $time);
      $fatal(1);
   end

   // ---------------- directed checks and stimulus ----------------
   task automatic chk(string name, int act, int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_until_a(int st, int budget, string name);
      int k;
      k = 0;
      while (int'(a_st) != st && k < budget) begin
         step();
         k++;
      end
      chk(name, int'(a_st), st);
   endtask

   initial begin
      int pat[5] = '{1, 1, 0, 1, 1};
      int prev_st, alen, nrec, minv, maxv;
      bit counting;

      @(posedge clk);
      #1;
      chk("rst_a_state", int'(a_st), 0);
      chk("rst_a_x", int'(a_x), 798);
      chk("rst_a_y", int'(a_y), 470);
      chk("rst_a_vis", int'(a_vis), 0);
      chk("rst_a_spawn", int'(a_sp), 0);
      chk("rst_a_sweeps", int'(a_sw), 0);
      chk("rst_b_x", int'(b_x), 798);
      rst = 1'b0;

      // short arming with an idle tick in the middle
      level = 2'd0;
      tick  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         activity = pat[i][0];
         step();
         if (i == 3) chk("arm4_b_still_arming", int'(b_st), 0);
      end
      chk("arm4_b_state", int'(b_st), 1);
      chk("arm4_b_spawn", int'(b_sp), 1);
      chk("arm4_b_x", int'(b_x), 798);
      activity = 1'b0;
      tick     = 1'b0;
      step();
      chk("arm4_b_spawn_clears", int'(b_sp), 0);
      chk("arm4_b_tick0_holds_x", int'(b_x), 798);

      // random traffic, checked by the scoreboard
      for (int i = 0; i < 3000; i++) begin
         tick        = ($urandom_range(0, 3) != 0);
         activity    = 1'($urandom_range(0, 1));
         hooked      = ($urandom_range(0, 15) == 0);
         caught_done = ($urandom_range(0, 7) == 0);
         level       = 2'($urandom_range(0, 3));
         step();
      end

      // fresh start on dut_a for the sweep scenarios
      tick = 1'b0; activity = 1'b0; hooked = 1'b0; caught_done = 1'b0; level = 2'd0;
      rst = 1'b1;
      #2;
      rst = 1'b0;
      tick = 1'b1;
      activity = 1'b1;
      run_until_a(1, 600, "a_first_spawn");
      chk("a_spawn_pulse", int'(a_sp), 1);
      chk("a_spawn_x", int'(a_x), 798);
      chk("a_spawn_vis", int'(a_vis), 1);
      repeat (327) step();
      chk("l0_x_at_327", int'(a_x), 144);
      chk("l0_state_at_327", int'(a_st), 1);

      // hook on what would have been the wrap tick
      hooked = 1'b1;
      step();
      chk("hook_state", int'(a_st), 2);
      chk("hook_x", int'(a_x), 144);
      chk("hook_sweeps", int'(a_sw), 0);
      repeat (3) step();
      hooked = 1'b0;
      chk("hooked_x_holds", int'(a_x), 144);
      chk("hooked_y_holds", int'(a_y), 470);
      level = 2'd1;
      caught_done = 1'b1;
      step();
      caught_done = 1'b0;
      chk("caught_state", int'(a_st), 0);
      chk("caught_y", int'(a_y), 380);
      chk("caught_x", int'(a_x), 798);
      chk("caught_vis", int'(a_vis), 0);

      // level 3: lane 200, step 5
      level = 2'd3;
      run_until_a(1, 600, "l3_spawn");
      chk("l3_y", int'(a_y), 200);
      repeat (130) step();
      chk("l3_x_at_130", int'(a_x), 148);
      step();
      chk("l3_wrap_x", int'(a_x), 798);
      chk("l3_wrap_state", int'(a_st), 0);
      chk("l3_wrap_sweeps", int'(a_sw), 1);

      // level 0 full sweep and wrap
      level = 2'd0;
      run_until_a(1, 600, "l0_spawn");
      repeat (327) step();
      chk("l0_x_before_wrap", int'(a_x), 144);
      step();
      chk("l0_wrap_x", int'(a_x), 798);
      chk("l0_wrap_state", int'(a_st), 0);
      chk("l0_wrap_sweeps", int'(a_sw), 2);

      // reset in the middle of a sweep takes effect without a clock edge
      run_until_a(1, 600, "pre_reset_spawn");
      repeat (20) step();
      rst = 1'b1;
      #1;
      chk("midrst_state", int'(a_st), 0);
      chk("midrst_x", int'(a_x), 798);
      chk("midrst_y", int'(a_y), 470);
      chk("midrst_vis", int'(a_vis), 0);
      chk("midrst_sweeps", int'(a_sw), 0);
      #1;
      rst = 1'b0;

      // long run: jittered arming on dut_a, saturation on dut_b
      level = 2'd3; tick = 1'b1; activity = 1'b1; hooked = 1'b0; caught_done = 1'b0;
      prev_st = 0; alen = 0; nrec = 0; minv = 10000; maxv = -1; counting = 1'b0;
      for (int i = 0; i < 42000; i++) begin
         step();
         if (prev_st == 1 && int'(a_st) == 0) begin
            counting = 1'b1;
            alen = 1;
         end else if (counting && int'(a_st) == 0) begin
            alen++;
         end else if (counting && int'(a_st) == 1 && a_sp) begin
            counting = 1'b0;
            nrec++;
            if (alen < minv) minv = alen;
            if (alen > maxv) maxv = alen;
            n_tests++;
            if (alen < 400 || alen > 463) begin
               n_fail++;
               $display("FAIL jitter_range: got arming length %0d required 400..463", alen);
            end
         end
         prev_st = int'(a_st);
      end
      chk("jitter_enough_samples", int'(nrec >= 50), 1);
      chk("jitter_not_constant", int'(maxv != minv), 1);
      chk("b_sweeps_saturated", int'(b_sw), 255);

      tick = 1'b0;
      activity = 1'b0;
      @(negedge clk);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
